// File: rtl/neuron_accumulate_activate.sv
// Accumulates signed synapse partial sums per neuron on top of a bias, then
// presents a saturated 8-bit pre-activation and a binary activation.
module neuron_accumulate_activate #(
    parameter int unsigned SUM_W      = 7,
    parameter int unsigned ACC_W      = 12,
    parameter int unsigned MAX_CHUNKS = 31
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [SUM_W-1:0] in_sum,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic signed [7:0]       bias,
    input  logic                    bias_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_preact,
    output logic                    out_act,
    output logic [4:0]              out_count,
    output logic                    out_trunc
);

    // Accumulator is widened beyond ACC_W when the worst-case sum needs it, so it can never wrap.
    localparam int unsigned SUM_MAG = 1 << (SUM_W - 1);
    localparam int unsigned NEED_W  = $clog2(128 + MAX_CHUNKS * SUM_MAG + 1) + 1;
    localparam int unsigned AW      = (ACC_W > NEED_W) ? ACC_W : NEED_W;
    localparam int unsigned CNT_W   = $clog2(MAX_CHUNKS + 1);

    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_CHUNKS);
    localparam logic signed [AW-1:0] SAT_HI  = AW'(127);
    localparam logic signed [AW-1:0] SAT_LO  = AW'(-128);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic signed [7:0]      bias_q, bias_d;
    logic                   ov_d, oa_d, ot_d;
    logic signed [7:0]      op_d;
    logic [4:0]             oc_d;

    logic                   accept;
    logic signed [AW-1:0]   upd_acc;
    logic [CNT_W-1:0]       upd_cnt;
    logic                   closing;
    logic signed [7:0]      sat;

    assign in_ready = (state_q != HOLD) && !rst;
    assign accept   = in_valid && in_ready;

    // Candidate accumulator/count if the current chunk is taken.
    always_comb begin
        upd_acc = ((state_q == IDLE) ? AW'(bias_q) : acc_q) + AW'(in_sum);
        upd_cnt = ((state_q == IDLE) ? '0 : cnt_q) + CNT_W'(1);
        closing = in_last || (upd_cnt == CNT_MAX);
        if (upd_acc > SAT_HI) begin
            sat = 8'sd127;
        end else if (upd_acc < SAT_LO) begin
            sat = -8'sd128;
        end else begin
            sat = 8'(upd_acc);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_we ? bias : bias_q;
        ov_d    = out_valid;
        op_d    = out_preact;
        oa_d    = out_act;
        oc_d    = out_count;
        ot_d    = out_trunc;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = upd_acc;
                    cnt_d = upd_cnt;
                    if (closing) begin
                        state_d = HOLD;
                        ov_d    = 1'b1;
                        op_d    = sat;
                        oa_d    = !upd_acc[AW-1] && (upd_acc != '0);
                        oc_d    = 5'(upd_cnt);
                        ot_d    = !in_last;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= '0;
            out_valid  <= 1'b0;
            out_preact <= '0;
            out_act    <= 1'b0;
            out_count  <= '0;
            out_trunc  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bias_q     <= bias_d;
            out_valid  <= ov_d;
            out_preact <= op_d;
            out_act    <= oa_d;
            out_count  <= oc_d;
            out_trunc  <= ot_d;
        end
    end

endmodule

// File: tb/tb_neuron_accumulate_activate.sv
// Directed and randomized checks of neuron_accumulate_activate against a
// transaction-level model of the accumulate / hold behaviour.
module tb_neuron_accumulate_activate;

    logic       clk;
    logic       rst;
    logic [6:0] in_sum;
    logic       in_valid, in_last, in_ready;
    logic [7:0] bias;
    logic       bias_we;
    logic       out_valid, out_ready;
    logic [7:0] out_preact;
    logic       out_act;
    logic [4:0] out_count;
    logic       out_trunc;

    int vectors = 0;
    int errors  = 0;

    int m_bias, m_acc, m_cnt;
    bit m_open;
    bit exp_valid, exp_act, exp_trunc;
    int exp_preact, exp_count;

    neuron_accumulate_activate dut (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .bias(bias), .bias_we(bias_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_preact(out_preact),
        .out_act(out_act), .out_count(out_count), .out_trunc(out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the model advances by the same edge and outputs are sampled #1 after it.
    task automatic step(input bit v, input int s, input bit l, input bit bwe, input int b, input bit ordy);
        @(negedge clk);
        in_valid  = v;
        in_sum    = 7'(s);
        in_last   = l;
        bias_we   = bwe;
        bias      = 8'(b);
        out_ready = ordy;
        if (exp_valid) begin
            if (ordy) exp_valid = 1'b0;
        end else if (v) begin
            if (!m_open) begin
                m_acc = m_bias + s;
                m_cnt = 1;
            end else begin
                m_acc = m_acc + s;
                m_cnt = m_cnt + 1;
            end
            m_open = 1'b1;
            if (l || m_cnt == 31) begin
                exp_valid  = 1'b1;
                exp_preact = (m_acc > 127) ? 127 : (m_acc < -128) ? -128 : m_acc;
                exp_act    = (m_acc > 0);
                exp_count  = m_cnt;
                exp_trunc  = !l;
                m_open     = 1'b0;
            end
        end
        if (bwe) m_bias = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; bias_we = 1'b0; out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        m_bias = 0; m_open = 1'b0; exp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset(2);
        vectors++;
        if ({out_valid, out_preact, out_act, out_count, out_trunc} !== 16'h0) begin
            errors++; $display("FAIL reset_outs: got v=%b p=%h a=%b c=%0d t=%b want all 0",
                                out_valid, out_preact, out_act, out_count, out_trunc);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        step(1, 5, 1, 0, 0, 0);
        vectors++;
        if ({out_valid, out_preact, out_act, out_count, out_trunc} !== {1'b1, 8'd5, 1'b1, 5'd1, 1'b0}) begin
            errors++; $display("FAIL single: got v=%b p=%h a=%b c=%0d t=%b want 1 05 1 1 0",
                                out_valid, out_preact, out_act, out_count, out_trunc);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_multi();
        step(0, 0, 0, 1, -3, 0);
        step(1, 2, 0, 0, 0, 0);
        step(1, -1, 0, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL multi_early_valid: got %b want 0", out_valid);
        end
        step(1, 1, 1, 0, 0, 0);
        vectors++;
        if ({out_valid, out_preact, out_act, out_count, out_trunc} !== {1'b1, 8'hFF, 1'b0, 5'd3, 1'b0}) begin
            errors++; $display("FAIL multi: got v=%b p=%h a=%b c=%0d t=%b want 1 ff 0 3 0",
                                out_valid, out_preact, out_act, out_count, out_trunc);
        end
    endtask

    // Relies on the -1 result left pending by test_multi.
    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            step(1, int'($urandom_range(127)) - 64, 1, 0, 0, 0);
            vectors++;
            if ({out_valid, out_preact, out_act, out_count, out_trunc, in_ready} !== {1'b1, 8'hFF, 1'b0, 5'd3, 1'b0, 1'b0}) begin
                errors++; $display("FAIL hold_stable[%0d]: got v=%b p=%h a=%b c=%0d t=%b rdy=%b want 1 ff 0 3 0 0",
                                    i, out_valid, out_preact, out_act, out_count, out_trunc, in_ready);
            end
        end
        step(1, 5, 1, 0, 0, 1);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL hold_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        step(0, 0, 0, 0, 0, 1);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_no_ghost_chunk: got %b want 0", out_valid);
        end
    endtask

    task automatic test_trunc(input int b, input int s, input logic [7:0] want_p, input bit want_a);
        step(0, 0, 0, 1, b, 0);
        for (int i = 0; i < 30; i++) step(1, s, 0, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL trunc_early_valid: got %b want 0", out_valid);
        end
        step(1, s, 0, 0, 0, 0);
        vectors++;
        if ({out_valid, out_preact, out_act, out_count, out_trunc} !== {1'b1, want_p, want_a, 5'd31, 1'b1}) begin
            errors++; $display("FAIL trunc: got v=%b p=%h a=%b c=%0d t=%b want 1 %h %b 31 1",
                                out_valid, out_preact, out_act, out_count, out_trunc, want_p, want_a);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1, 10, 0);
        step(1, 3, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0);
        do_reset(1);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_valid: got %b want 0", out_valid);
        end
        step(1, -7, 1, 0, 0, 0);
        vectors++;
        if ({out_valid, out_preact, out_count, out_trunc} !== {1'b1, 8'hF9, 5'd1, 1'b0}) begin
            errors++; $display("FAIL reset_mid: got v=%b p=%h c=%0d t=%b want 1 f9 1 0",
                                out_valid, out_preact, out_count, out_trunc);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_bias_same_cycle();
        step(1, 1, 0, 1, 20, 0);
        step(1, 0, 1, 0, 0, 0);
        vectors++;
        if ({out_valid, out_preact, out_count} !== {1'b1, 8'd1, 5'd2}) begin
            errors++; $display("FAIL bias_old: got v=%b p=%h c=%0d want 1 01 2", out_valid, out_preact, out_count);
        end
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        vectors++;
        if ({out_valid, out_preact} !== {1'b1, 8'd20}) begin
            errors++; $display("FAIL bias_new: got v=%b p=%h want 1 14", out_valid, out_preact);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(3) != 0, int'($urandom_range(127)) - 64, $urandom_range(7) == 0,
                 $urandom_range(15) == 0, int'($urandom_range(255)) - 128, $urandom_range(2) != 0);
            vectors++;
            if ({out_valid, in_ready} !== {exp_valid, !exp_valid}) begin
                errors++; $display("FAIL rand_handshake[%0d]: got v=%b rdy=%b want v=%b rdy=%b",
                                    i, out_valid, in_ready, exp_valid, !exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if ({out_preact, out_act, out_count, out_trunc} !== {8'(exp_preact), exp_act, 5'(exp_count), exp_trunc}) begin
                    errors++; $display("FAIL rand_result[%0d]: got p=%0d a=%b c=%0d t=%b want p=%0d a=%b c=%0d t=%b",
                                        i, $signed(out_preact), out_act, out_count, out_trunc,
                                        exp_preact, exp_act, exp_count, exp_trunc);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_sum = '0; in_valid = 1'b0; in_last = 1'b0;
        bias = '0; bias_we = 1'b0; out_ready = 1'b0;
        m_bias = 0; m_acc = 0; m_cnt = 0; m_open = 1'b0; exp_valid = 1'b0;
        exp_act = 1'b0; exp_trunc = 1'b0; exp_preact = 0; exp_count = 0;
        test_reset();
        test_single();
        test_multi();
        test_hold();
        test_trunc(127, 32, 8'h7F, 1'b1);
        test_trunc(-128, -64, 8'h80, 1'b0);
        test_reset_mid();
        test_bias_same_cycle();
        test_random(1500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
